// File: rtl/axi_master_req_scheduler_pkg.sv
// Shared AXI-master definitions: default field widths, starvation limit and
// scheduler FSM state encoding.
package axi_master_req_scheduler_pkg;

  localparam int AXLEN_FIELD_WIDTH_DEFAULT = 8;
  localparam int SEQ_WIDTH_DEFAULT         = 8;
  localparam int STARVE_LIMIT_DEFAULT      = 4;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_P_DATA = 1'b1
  } sched_state_e;

endpackage

// File: rtl/axi_master_req_scheduler_seq_age_compare.sv
// Wrap-safe arrival-age comparison: np_older is set when the NP tag was issued
// strictly before the posted tag, within half the tag space.
module seq_age_compare
  import axi_master_req_scheduler_pkg::*;
#(
  parameter int SEQ_WIDTH = SEQ_WIDTH_DEFAULT
) (
  input  logic [SEQ_WIDTH-1:0] p_seq,
  input  logic [SEQ_WIDTH-1:0] np_seq,
  output logic                 np_older
);

  logic [SEQ_WIDTH-1:0] diff;

  assign diff     = p_seq - np_seq;
  assign np_older = (diff != '0) && !diff[SEQ_WIDTH-1];

endmodule

// File: rtl/axi_master_req_scheduler.sv
// Schedules posted write bursts and non-posted reads into AXI AW/W/AR FIFOs,
// honouring arrival order with a bounded starvation window for older reads.
module axi_master_req_scheduler
  import axi_master_req_scheduler_pkg::*;
#(
  parameter int AxLEN_FIELD_WIDTH = AXLEN_FIELD_WIDTH_DEFAULT,
  parameter int SEQ_WIDTH         = SEQ_WIDTH_DEFAULT,
  parameter int STARVE_LIMIT      = STARVE_LIMIT_DEFAULT
) (
  input  logic                         i_clk,
  input  logic                         i_n_rst,
  input  logic                         i_p_hdr_valid,
  input  logic [SEQ_WIDTH-1:0]         i_p_seq,
  input  logic [AxLEN_FIELD_WIDTH-1:0] i_p_len,
  output logic                         o_p_hdr_pop,
  input  logic                         i_p_data_valid,
  output logic                         o_p_data_pop,
  input  logic                         i_np_hdr_valid,
  input  logic [SEQ_WIDTH-1:0]         i_np_seq,
  output logic                         o_np_hdr_pop,
  input  logic                         i_aw_fifo_full,
  output logic                         o_aw_fifo_push,
  input  logic                         i_w_fifo_full,
  output logic                         o_w_fifo_push,
  output logic                         o_w_last,
  input  logic                         i_ar_fifo_full,
  output logic                         o_ar_fifo_push,
  output logic                         o_busy
);

  localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int BEAT_W   = AxLEN_FIELD_WIDTH + 1;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  sched_state_e         state;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [STARVE_W-1:0]  starve_cnt;
  logic                 np_older;
  logic                 np_eligible;
  logic                 np_sel;
  logic                 p_sel;
  logic                 np_fire;
  logic                 p_fire;
  logic                 beat_fire;

  seq_age_compare #(
    .SEQ_WIDTH (SEQ_WIDTH)
  ) u_age (
    .p_seq    (i_p_seq),
    .np_seq   (i_np_seq),
    .np_older (np_older)
  );

  // An older read only overtakes waiting posted traffic once the starvation
  // window is exhausted; with no posted header it goes straight through.
  assign np_eligible = i_np_hdr_valid && (!i_p_hdr_valid || np_older);
  assign np_sel      = (state == S_IDLE) && np_eligible &&
                       (!i_p_hdr_valid || starve_cnt == STARVE_MAX);
  assign p_sel       = (state == S_IDLE) && !np_sel && i_p_hdr_valid;

  assign np_fire   = i_n_rst && np_sel && !i_ar_fifo_full;
  assign p_fire    = i_n_rst && p_sel && !i_aw_fifo_full;
  assign beat_fire = i_n_rst && (state == S_P_DATA) && i_p_data_valid && !i_w_fifo_full;

  assign o_ar_fifo_push = np_fire;
  assign o_np_hdr_pop   = np_fire;
  assign o_aw_fifo_push = p_fire;
  assign o_p_hdr_pop    = p_fire;
  assign o_w_fifo_push  = beat_fire;
  assign o_p_data_pop   = beat_fire;
  assign o_w_last       = beat_fire && (beat_cnt == BEAT_W'(1));

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      state      <= S_IDLE;
      beat_cnt   <= '0;
      starve_cnt <= '0;
      o_busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (p_fire) begin
            state    <= S_P_DATA;
            o_busy   <= 1'b1;
            beat_cnt <= BEAT_W'(i_p_len) + BEAT_W'(1);
          end
        end
        S_P_DATA: begin
          if (beat_fire) begin
            beat_cnt <= beat_cnt - BEAT_W'(1);
            if (beat_cnt == BEAT_W'(1)) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end
          end
        end
      endcase

      if (!i_np_hdr_valid || np_fire) begin
        starve_cnt <= '0;
      end else if (p_fire && np_eligible && starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end

endmodule
